systolic_feeder: RTL and testbench
==================================

// Module: systolic_feeder
// PURPOSE
//  Transmit side of the systolic_array operand interface. Buffers one N x N matrix A
//  and one N x N matrix B, written one row per beat over a valid/ready port. On start,
//  streams them into the array: column k of A and row k of B on beat k. Then drives
//  zero flush beats until the array's products are complete.
//  Sits between the host/DMA row stream and systolic_array.valid_in/matrix_a_in/matrix_b_in.
// PARAMETERS
//  DATAWIDTH    16                 element width, bits
//  N_SIZE       5                  matrix dimension; must equal the array's N_SIZE
//  FLUSH_BEATS  2*N_SIZE-1 (lparam) zero beats driven after the last data beat
// PORTS
//  clk        in   1            clock, rising edge
//  rst_n      in   1            reset, asynchronous, active-low
//  s_valid    in   1            host row beat valid
//  s_ready    out  1            feeder accepts a row this cycle
//  s_data     in   N*DW         row; element c in [c*DW +: DW]
//  start      in   1            launch request; honoured only in ARMED
//  busy       out  1            1 in STREAM or FLUSH
//  arr_valid  out  1            to systolic_array.valid_in
//  arr_a      out  N*DW         to matrix_a_in; element i = A[i][k]
//  arr_b      out  N*DW         to matrix_b_in; element j = B[k][j]
//  done       out  1            one-cycle pulse on the last FLUSH cycle
// BEHAVIOUR
//  Reset values:
//   - state=LOAD_A; all counters 0.
//   - s_ready=1; busy=0; arr_valid=0; arr_a=0; arr_b=0; done=0.
//   - Matrix storage is not reset; contents stay undefined until rewritten.
//  FSM: LOAD_A -> LOAD_B -> ARMED -> STREAM -> FLUSH -> LOAD_A.
//  Row transfer:
//   - A transfer occurs on s_valid && s_ready. s_ready is 1 in LOAD_A/LOAD_B only.
//   - row_cnt (clog2 N bits) selects the destination row. It wraps to 0 after row N-1
//     and the state advances (A then B).
//   - s_valid held while s_ready=0 is stalled. Nothing is captured and no error is raised.
//  ARMED:
//   - start=1 moves the FSM to STREAM on the next edge.
//   - start in any other state is ignored and is not remembered.
//  STREAM:
//   - Exactly N cycles; beat counter k runs 0..N-1.
//   - Outputs are registered: arr_valid=1 with arr_a/arr_b = beat k, beginning the cycle
//     after start is sampled.
//  FLUSH:
//   - FLUSH_BEATS cycles with arr_valid=0 and arr_a=arr_b=0.
//   - done=1 on the final FLUSH cycle only. The next cycle is LOAD_A with s_ready=1.
//  Latency and storage:
//   - Last B row accepted to ARMED: 1 cycle.
//   - start to first arr_valid: 1 cycle.
//   - start to done: N+FLUSH_BEATS cycles.
//   - Data is pass-through with no arithmetic. Unsigned storage, width DATAWIDTH.
//  Reset mid-operation (any state): return to reset values next edge. Partial loads are
//   discarded and a full reload of A then B is required.
//  A and B buffers are never read and written in the same cycle, because their states
//   are disjoint.
// STRUCTURE
//  systolic_pkg:
//   - feeder_state_e enum {LOAD_A, LOAD_B, ARMED, STREAM, FLUSH}.
//   - Default DATAWIDTH/N_SIZE constants, shared with systolic_array.
//  Sub-module feeder_matrix_bank, instantiated twice:
//   - N x N register file with a row write port (we, row, data).
//   - Combinational read of either a column (A) or a row (B), chosen by a parameter.
// TESTING (N_SIZE=3, DATAWIDTH=8)
//  1 Load A=[[1,2,3],[4,5,6],[7,8,9]] and B=I, then start.
//    -> arr_a beats {1,4,7},{2,5,8},{3,6,9}; arr_b beats {1,0,0},{0,1,0},{0,0,1};
//       arr_valid high 3 cycles, then 5 zero beats, done on the 5th.
//  2 Toggle s_valid randomly during loading.
//    -> exactly 6 transfers, row order preserved, s_ready falls after the 6th.
//  3 Pulse start during LOAD_B and again in FLUSH.
//    -> no effect: arr_valid stays 0 until a start issued in ARMED.
//  4 Hold s_valid=1 with new data while ARMED/STREAM.
//    -> s_ready=0, stored A/B unchanged, streamed beats match scenario 1.
//  5 Assert rst_n=0 on STREAM beat 1.
//    -> all outputs 0 next cycle, s_ready=1, and the FSM requires 6 fresh rows before ARMED.
//  6 Back-to-back jobs feeding a systolic_array instance.
//    -> matrix_c_out matches a golden A*B for each job; s_ready reasserts the cycle after done.

Source files
------------

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and defaults for the systolic array operand path
package systolic_pkg;

  localparam int DEF_DATAWIDTH = 16;
  localparam int DEF_N_SIZE    = 5;

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    ARMED,
    STREAM,
    FLUSH
  } feeder_state_e;

  // Zero beats needed for the last operands to ripple through an n x n array.
  function automatic int feeder_flush_beats(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/feeder_matrix_bank.sv
// rtl/feeder_matrix_bank.sv - N x N operand register file, row write, row or column read
module feeder_matrix_bank #(
  parameter int DATAWIDTH = 16,
  parameter int N_SIZE    = 5,
  parameter bit READ_COL  = 1'b0,
  localparam int RW       = (N_SIZE > 1) ? $clog2(N_SIZE) : 1
) (
  input  logic                          clk,
  input  logic                          i_we,
  input  logic [RW-1:0]                 i_row,
  input  logic [N_SIZE*DATAWIDTH-1:0]   i_data,
  input  logic [RW-1:0]                 i_sel,
  output logic [N_SIZE*DATAWIDTH-1:0]   o_data
);

  // Storage is deliberately unreset; every job rewrites all rows before use.
  logic [N_SIZE-1:0][DATAWIDTH-1:0] r_mem [N_SIZE];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_row] <= i_data;
    end
  end

  generate
    if (READ_COL) begin : g_col
      for (genvar i = 0; i < N_SIZE; i++) begin : g_elem
        assign o_data[i*DATAWIDTH +: DATAWIDTH] = r_mem[i][i_sel];
      end
    end else begin : g_row
      assign o_data = r_mem[i_sel];
    end
  endgenerate

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - buffers matrices A and B from a row stream and feeds them
// into the systolic array one k-beat at a time, followed by zero flush beats
module systolic_feeder #(
  parameter int DATAWIDTH = systolic_pkg::DEF_DATAWIDTH,
  parameter int N_SIZE    = systolic_pkg::DEF_N_SIZE
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [N_SIZE*DATAWIDTH-1:0] s_data,
  input  logic                        start,
  output logic                        busy,
  output logic                        arr_valid,
  output logic [N_SIZE*DATAWIDTH-1:0] arr_a,
  output logic [N_SIZE*DATAWIDTH-1:0] arr_b,
  output logic                        done
);

  import systolic_pkg::*;

  localparam int FLUSH_BEATS = feeder_flush_beats(N_SIZE);
  localparam int RW          = (N_SIZE > 1) ? $clog2(N_SIZE) : 1;
  localparam int KW          = $clog2(FLUSH_BEATS + 1);
  localparam int VW          = N_SIZE * DATAWIDTH;

  feeder_state_e     r_state;
  logic [RW-1:0]     r_row;
  logic [KW-1:0]     r_k;
  logic              r_s_ready;
  logic              r_busy;
  logic              r_arr_valid;
  logic [VW-1:0]     r_arr_a;
  logic [VW-1:0]     r_arr_b;
  logic              r_done;

  logic              w_xfer;
  logic              w_last_row;
  logic [KW-1:0]     w_k_inc;
  logic [RW-1:0]     w_rd_idx;
  logic [VW-1:0]     w_col_a;
  logic [VW-1:0]     w_row_b;

  assign w_xfer     = s_valid && r_s_ready;
  assign w_last_row = (r_row == RW'(N_SIZE - 1));
  assign w_k_inc    = r_k + 1'b1;

  // Outputs are registered, so the banks are read one beat ahead of what is displayed.
  assign w_rd_idx = (r_state == STREAM && r_k != KW'(N_SIZE - 1)) ? w_k_inc[RW-1:0] : '0;

  feeder_matrix_bank #(
    .DATAWIDTH (DATAWIDTH),
    .N_SIZE    (N_SIZE),
    .READ_COL  (1'b1)
  ) u_bank_a (
    .clk    (clk),
    .i_we   (r_state == LOAD_A && w_xfer),
    .i_row  (r_row),
    .i_data (s_data),
    .i_sel  (w_rd_idx),
    .o_data (w_col_a)
  );

  feeder_matrix_bank #(
    .DATAWIDTH (DATAWIDTH),
    .N_SIZE    (N_SIZE),
    .READ_COL  (1'b0)
  ) u_bank_b (
    .clk    (clk),
    .i_we   (r_state == LOAD_B && w_xfer),
    .i_row  (r_row),
    .i_data (s_data),
    .i_sel  (w_rd_idx),
    .o_data (w_row_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LOAD_A;
      r_row       <= '0;
      r_k         <= '0;
      r_s_ready   <= 1'b1;
      r_busy      <= 1'b0;
      r_arr_valid <= 1'b0;
      r_arr_a     <= '0;
      r_arr_b     <= '0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        LOAD_A: begin
          if (w_xfer) begin
            if (w_last_row) begin
              r_row   <= '0;
              r_state <= LOAD_B;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (w_xfer) begin
            if (w_last_row) begin
              r_row     <= '0;
              r_state   <= ARMED;
              r_s_ready <= 1'b0;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end
        end
        ARMED: begin
          if (start) begin
            r_state     <= STREAM;
            r_k         <= '0;
            r_busy      <= 1'b1;
            r_arr_valid <= 1'b1;
            r_arr_a     <= w_col_a;
            r_arr_b     <= w_row_b;
          end
        end
        STREAM: begin
          if (r_k == KW'(N_SIZE - 1)) begin
            r_state     <= FLUSH;
            r_k         <= '0;
            r_arr_valid <= 1'b0;
            r_arr_a     <= '0;
            r_arr_b     <= '0;
            r_done      <= (FLUSH_BEATS == 1);
          end else begin
            r_k     <= w_k_inc;
            r_arr_a <= w_col_a;
            r_arr_b <= w_row_b;
          end
        end
        FLUSH: begin
          if (r_k == KW'(FLUSH_BEATS - 1)) begin
            r_state   <= LOAD_A;
            r_k       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_s_ready <= 1'b1;
          end else begin
            r_k    <= w_k_inc;
            r_done <= (w_k_inc == KW'(FLUSH_BEATS - 1));
          end
        end
        default: begin
          r_state <= LOAD_A;
        end
      endcase
    end
  end

  assign s_ready   = r_s_ready;
  assign busy      = r_busy;
  assign arr_valid = r_arr_valid;
  assign arr_a     = r_arr_a;
  assign arr_b     = r_arr_b;
  assign done      = r_done;

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - scoreboard bench for systolic_feeder at N_SIZE=3, DATAWIDTH=8
module tb_systolic_feeder;

  localparam int DW = 8;
  localparam int N  = 3;
  localparam int F  = 2 * N - 1;
  localparam int RW = N * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          start = 1'b0;
  logic [RW-1:0] s_data = '0;
  logic          s_ready;
  logic          busy;
  logic          arr_valid;
  logic          done;
  logic [RW-1:0] arr_a;
  logic [RW-1:0] arr_b;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0]   ma [N][N];
  logic [DW-1:0]   mb [N][N];
  logic [2*RW-1:0] exp_q [$];

  always #5 clk = ~clk;

  systolic_feeder #(
    .DATAWIDTH (DW),
    .N_SIZE    (N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .start     (start),
    .busy      (busy),
    .arr_valid (arr_valid),
    .arr_a     (arr_a),
    .arr_b     (arr_b),
    .done      (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] row_of(input int r);
    logic [RW-1:0] v;
    for (int c = 0; c < N; c++) begin
      v[c*DW +: DW] = (r < N) ? ma[r][c] : mb[r-N][c];
    end
    return v;
  endfunction

  task automatic push_job();
    logic [RW-1:0] a;
    logic [RW-1:0] b;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        a[i*DW +: DW] = ma[i][k];
        b[i*DW +: DW] = mb[k][i];
      end
      exp_q.push_back({a, b});
    end
  endtask

  task automatic check_idle(input string tag, input logic exp_ready);
    check({tag, "_s_ready"}, 64'(s_ready), 64'(exp_ready));
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_valid"}, 64'(arr_valid), 64'd0);
    check({tag, "_a"}, 64'(arr_a), 64'd0);
    check({tag, "_b"}, 64'(arr_b), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
  endtask

  // Returns at the negedge following the last posedge; s_valid/start are cleared there.
  task automatic load_rows(input int first, input int count, input bit rnd, input bit start_pulse);
    int idx;
    int guard;
    logic xfer;
    idx = first;
    guard = 0;
    while (idx < first + count && guard < 300) begin
      @(negedge clk);
      guard++;
      check("load_s_ready", 64'(s_ready), 64'd1);
      check("load_no_valid", 64'(arr_valid), 64'd0);
      s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = s_valid ? row_of(idx) : RW'($urandom);
      start   = start_pulse && (idx >= N);
      xfer    = s_valid && s_ready;
      @(posedge clk);
      if (xfer) idx++;
    end
    if (guard >= 300) check("load_timeout", 64'd0, 64'd1);
    @(negedge clk);
    s_valid = 1'b0;
    start   = 1'b0;
  endtask

  task automatic run_stream(input bit hold, input bit flush_start);
    logic [2*RW-1:0] e;
    for (int c = 1; c <= N + F; c++) begin
      if (c > 1) @(negedge clk);
      check("busy", 64'(busy), 64'd1);
      check("done", 64'(done), 64'(c == N + F));
      if (c <= N) begin
        check("arr_valid", 64'(arr_valid), 64'd1);
        if (exp_q.size() == 0) begin
          check("queue_empty", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("arr_a", 64'(arr_a), 64'(e[2*RW-1:RW]));
          check("arr_b", 64'(arr_b), 64'(e[RW-1:0]));
        end
      end else begin
        check("flush_valid", 64'(arr_valid), 64'd0);
        check("flush_a", 64'(arr_a), 64'd0);
        check("flush_b", 64'(arr_b), 64'd0);
      end
      if (hold) check("hold_s_ready", 64'(s_ready), 64'd0);
      s_valid = hold && (c < N + F);
      s_data  = RW'($urandom);
      start   = flush_start && (c > N);
    end
    @(negedge clk);
    start   = 1'b0;
    s_valid = 1'b0;
    check_idle("after_done", 1'b1);
  endtask

  task automatic start_job(input bit hold, input bit flush_start);
    @(negedge clk);
    check("armed_s_ready", 64'(s_ready), 64'd0);
    start = 1'b1;
    push_job();
    @(negedge clk);
    start = 1'b0;
    run_stream(hold, flush_start);
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, 64'(arr_valid), 64'd0);
    end
  endtask

  task automatic rand_matrices();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ma[i][j] = DW'($urandom);
        mb[i][j] = DW'($urandom);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ma[i][j] = DW'(i * N + j + 1);
        mb[i][j] = (i == j) ? 8'd1 : 8'd0;
      end
    end

    repeat (2) @(negedge clk);
    check_idle("reset", 1'b1);
    rst_n = 1'b1;

    // Fixed A, identity B, steady valid.
    load_rows(0, 2 * N, 1'b0, 1'b0);
    check("loaded_s_ready", 64'(s_ready), 64'd0);
    start_job(1'b0, 1'b0);

    // Random valid gaps, start pulsed in LOAD_B and in FLUSH.
    rand_matrices();
    load_rows(0, 2 * N, 1'b1, 1'b1);
    check("loaded_rnd_s_ready", 64'(s_ready), 64'd0);
    idle_cycles("armed_no_autostart", 3);
    start_job(1'b0, 1'b1);
    idle_cycles("load_a_no_start", 3);

    // Garbage held on the row port while armed and streaming.
    load_rows(0, 2 * N, 1'b1, 1'b0);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = RW'($urandom);
    repeat (3) begin
      @(negedge clk);
      check("armed_hold_s_ready", 64'(s_ready), 64'd0);
      s_data = RW'($urandom);
    end
    start_job(1'b1, 1'b0);

    // Reset on stream beat 1, then a partial load must not arm.
    rand_matrices();
    load_rows(0, 2 * N, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("pre_reset_beat0", 64'(arr_valid), 64'd1);
    @(negedge clk);
    check("pre_reset_beat1", 64'(arr_valid), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle("mid_reset", 1'b1);
    rst_n = 1'b1;
    load_rows(0, 2 * N - 1, 1'b1, 1'b0);
    check("partial_s_ready", 64'(s_ready), 64'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("partial_no_stream", 64'(arr_valid), 64'd0);
    check("partial_still_ready", 64'(s_ready), 64'd1);
    load_rows(2 * N - 1, 1, 1'b0, 1'b0);
    check("reload_s_ready", 64'(s_ready), 64'd0);
    start_job(1'b0, 1'b0);

    // Back-to-back random jobs.
    for (int j = 0; j < 4; j++) begin
      rand_matrices();
      load_rows(0, 2 * N, 1'b1, 1'b0);
      start_job(1'b0, 1'b0);
    end

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
